// File: rtl/sa_autosa_sdp_pkg.sv
// sa_autosa_sdp_pkg: shared SDP DMA widths and RATIO helpers
`timescale 1ns/1ps
package sa_autosa_sdp_pkg;
  localparam int SDP_IW = 512;
  localparam int SDP_OW = 256;
  localparam int SDP_CW = 1;
  function automatic bit ratio_ok(input int r);
    return r == 1 || r == 2 || r == 4 || r == 8 || r == 16;
  endfunction
  function automatic int last_idx(input int r, input bit dp8);
    return r == 1 ? 0 : dp8 ? r - 1 : r / 2 - 1;
  endfunction
endpackage

// File: rtl/sa_autosa_sdp_wdma_unpack_seg_wr.sv
// sa_autosa_sdp_wdma_unpack_seg_wr: per-segment accumulator bank with decoded writes
// Ports: clk, rst_n (async, active-low); i_wr stores i_beat into segment i_idx;
// i_clr empties the bank when a word closes; o_word is the bank with segment
// i_idx replaced by i_beat (the word as it would close this cycle).
// With SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN: o_mask marks segments written so far,
// including i_idx.
`timescale 1ns/1ps
module sa_autosa_sdp_wdma_unpack_seg_wr #(
  parameter int OW = 256,
  parameter int RATIO = 2,
  parameter int CNTW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr,
  input  logic                i_clr,
  input  logic [CNTW-1:0]     i_idx,
  input  logic [OW-1:0]       i_beat,
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
  output logic [RATIO-1:0]    o_mask,
`endif
  output logic [RATIO*OW-1:0] o_word
);
  for (genvar g = 0; g < RATIO; g++) begin : g_seg
    logic [OW-1:0] r_seg;
    logic          w_sel;
    assign w_sel = i_idx == CNTW'(g);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_seg <= '0;
      else if (i_clr) r_seg <= '0;
      else if (i_wr && w_sel) r_seg <= i_beat;
    end
    assign o_word[g*OW +: OW] = w_sel ? i_beat : r_seg;
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
    logic r_bit;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_bit <= 1'b0;
      else if (i_clr) r_bit <= 1'b0;
      else if (i_wr && w_sel) r_bit <= 1'b1;
    end
    assign o_mask[g] = w_sel | r_bit;
`endif
  end
endmodule

// File: rtl/sa_autosa_sdp_wdma_unpack.sv
// sa_autosa_sdp_wdma_unpack: gathers OW-bit beats into IW-bit words for SDP write DMA
// Ports: autosa_core_clk, autosa_core_rstn (async, active-low); cfg_dp_8 selects
// RATIO (1) or RATIO/2 (0) beats per word; inp_* = {ctrl, data} beat stream,
// a set ctrl bit closes the word early; out_* = {ctrl, word} word stream.
// Optional macro SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN adds out_mask (segments written).
`timescale 1ns/1ps
module sa_autosa_sdp_wdma_unpack
  import sa_autosa_sdp_pkg::*;
#(
  parameter int IW = SDP_IW,
  parameter int CW = SDP_CW,
  parameter int OW = SDP_OW
) (
  input  logic             autosa_core_clk,
  input  logic             autosa_core_rstn,
  input  logic             cfg_dp_8,
  input  logic             inp_pvld,
  output logic             inp_prdy,
  input  logic [OW+CW-1:0] inp_data,
  output logic             out_pvld,
  input  logic             out_prdy,
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
  output logic [IW/OW-1:0] out_mask,
`endif
  output logic [IW+CW-1:0] out_data
);
  localparam int RATIO = IW / OW;
  localparam int CNTW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [CNTW-1:0] LAST_FULL = CNTW'(last_idx(RATIO, 1'b1));
  localparam logic [CNTW-1:0] LAST_HALF = CNTW'(last_idx(RATIO, 1'b0));
  if (!ratio_ok(RATIO) || RATIO * OW != IW) begin : g_bad_ratio
    $error("sa_autosa_sdp_wdma_unpack: IW/OW must be 1, 2, 4, 8 or 16");
  end
  logic [CNTW-1:0]  r_cnt;
  logic             r_out_pvld;
  logic [IW+CW-1:0] r_out_data;
  logic [CW-1:0]    w_ctrl;
  logic [CNTW-1:0]  w_last;
  logic             w_done;
  logic             w_inp_acc;
  logic [IW-1:0]    w_word;
  assign w_ctrl    = inp_data[OW+CW-1:OW];
  assign w_last    = cfg_dp_8 ? LAST_FULL : LAST_HALF;
  // >= so a word left past its end by a cfg change still closes on the next beat
  assign w_done    = r_cnt >= w_last || |w_ctrl;
  // only a closing beat needs the output register free
  assign inp_prdy  = !r_out_pvld || out_prdy || !w_done;
  assign w_inp_acc = inp_pvld && inp_prdy;
  assign out_pvld  = r_out_pvld;
  assign out_data  = r_out_data;
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
  logic [RATIO-1:0] w_mask;
  logic [RATIO-1:0] r_out_mask;
  assign out_mask = r_out_mask;
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) r_out_mask <= '0;
    else if (w_inp_acc && w_done) r_out_mask <= w_mask;
  end
`endif
  sa_autosa_sdp_wdma_unpack_seg_wr #(.OW(OW), .RATIO(RATIO), .CNTW(CNTW)) u_seg_wr (
    .clk    (autosa_core_clk),
    .rst_n  (autosa_core_rstn),
    .i_wr   (w_inp_acc && !w_done),
    .i_clr  (w_inp_acc && w_done),
    .i_idx  (r_cnt),
    .i_beat (inp_data[OW-1:0]),
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
    .o_mask (w_mask),
`endif
    .o_word (w_word)
  );
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      r_cnt      <= '0;
      r_out_pvld <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_inp_acc) r_cnt <= w_done ? '0 : r_cnt + CNTW'(1);
      if (w_inp_acc && w_done) begin
        r_out_pvld <= 1'b1;
        r_out_data <= {w_ctrl, w_word};
      end else if (out_prdy) r_out_pvld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sa_autosa_sdp_wdma_unpack.sv
// tb_sa_autosa_sdp_wdma_unpack: randomized self-checking bench for the beat-to-word unpacker
`timescale 1ns/1ps
module tb_sa_autosa_sdp_wdma_unpack;
  localparam int IW = 1024, OW = 256, CW = 1, R = IW / OW;
  typedef struct packed {logic [IW-1:0] d; logic c; logic [R-1:0] m;} word_t;
  logic clk = 0, rstn = 0, cfg = 1, cfg_nx = 1, inp_pvld = 0, out_prdy = 0, acc = 0;
  logic inp_prdy, out_pvld;
  logic [OW+CW-1:0] inp_data = '0;
  logic [IW+CW-1:0] out_data;
  logic [R-1:0] mask;
  int checks = 0, errors = 0, n_out = 0;
  word_t exp_q[$];
  logic [OW-1:0] pend[$];
  always #5 clk = ~clk;
  sa_autosa_sdp_wdma_unpack #(.IW(IW), .CW(CW), .OW(OW)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .cfg_dp_8        (cfg),
    .inp_pvld        (inp_pvld),
    .inp_prdy        (inp_prdy),
    .inp_data        (inp_data),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
    .out_mask        (mask),
`endif
    .out_data        (out_data)
  );
`ifndef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
  assign mask = '0;
`endif
  function automatic logic [OW-1:0] rnd();
    logic [OW-1:0] r;
    for (int i = 0; i < OW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // reference: a word is the list of accepted beats, closed by count or by ctrl
  function automatic void model_beat(input logic [OW-1:0] d, input logic c);
    word_t w;
    pend.push_back(d);
    if (c || pend.size() == (cfg ? R : R / 2)) begin
      w = '0;
      foreach (pend[i]) w.d[i*OW +: OW] = pend[i];
      w.c = c;
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
      w.m = R'((1 << pend.size()) - 1);
`endif
      exp_q.push_back(w);
      pend.delete();
    end
  endfunction
  task automatic tick(input logic pv, input logic [OW+CW-1:0] d, input logic pr);
    @(negedge clk);
    cfg = cfg_nx; inp_pvld = pv; inp_data = d; out_prdy = pr;
    #1;
    acc = pv && inp_prdy;
    if (acc) model_beat(d[OW-1:0], d[OW]);
  endtask
  task automatic send(input logic [OW-1:0] d, input logic c, input logic pr);
    int n = 0;
    do begin tick(1'b1, {c, d}, pr); n++; end while (!acc && n < 40);
    if (!acc) begin checks++; errors++; $display("FAIL send_timeout accepted=%b required=1", acc); end
  endtask
  // scoreboard: every accepted output word against the reference queue
  always @(negedge clk) begin
    word_t o, e;
    int s;
    #2;
    if (rstn && out_pvld && out_prdy) begin
      n_out++;
      checks++;
      o = {out_data[IW-1:0], out_data[IW], mask};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_word ctrl=%b seg0=%h required=none", o.c, o.d[OW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          s = 0;
          for (int i = R - 1; i >= 0; i--) if (o.d[i*OW +: OW] !== e.d[i*OW +: OW]) s = i;
          errors++;
          $display("FAIL sb_word seg=%0d got=%h required=%h ctrl=%b/%b mask=%b/%b",
                   s, o.d[s*OW +: OW], e.d[s*OW +: OW], o.c, e.c, o.m, e.m);
        end
      end
    end
  end
  task automatic test_reset();
    #3;
    checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL rst_pvld got=%b required=0", out_pvld); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data seg0=%h required=0", out_data[OW-1:0]); end
    checks++; if (mask !== '0) begin errors++; $display("FAIL rst_mask got=%b required=0", mask); end
    checks++; if (inp_prdy !== 1'b1) begin errors++; $display("FAIL rst_prdy got=%b required=1", inp_prdy); end
    @(negedge clk); rstn = 1;
  endtask
  task automatic test_full();
    logic [OW-1:0] b[4], r;
    cfg_nx = 1;
    for (int k = 0; k < 4; k++) begin
      r = rnd(); b[k] = {4'(4'hA + k), r[OW-5:0]};
      send(b[k], 1'b0, 1'b1);
      checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL full_early beat=%0d pvld=%b required=0", k, out_pvld); end
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== {1'b0, b[3], b[2], b[1], b[0]} || mask !== R'(15) && mask !== '0)
      begin errors++; $display("FAIL full_word pvld=%b seg3=%h required=%h", out_pvld, out_data[3*OW +: OW], b[3]); end
  endtask
  task automatic test_half();
    logic [OW-1:0] x, y;
    cfg_nx = 0; x = rnd(); y = rnd();
    send(x, 1'b0, 1'b1); send(y, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== {1'b0, {2*OW{1'b0}}, y, x})
      begin errors++; $display("FAIL half_word pvld=%b seg2=%h seg1=%h required_seg1=%h", out_pvld, out_data[2*OW +: OW], out_data[OW +: OW], y); end
  endtask
  task automatic test_flush();
    logic [OW-1:0] p, q, b[4];
    cfg_nx = 1; p = rnd(); q = rnd();
    send(p, 1'b0, 1'b1); send(q, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== {1'b1, {2*OW{1'b0}}, q, p})
      begin errors++; $display("FAIL flush_word pvld=%b ctrl=%b seg1=%h required=%h", out_pvld, out_data[IW], out_data[OW +: OW], q); end
`ifdef SA_AUTOSA_SDP_WDMA_UNPACK_MASK_EN
    checks++; if (mask !== 4'b0011) begin errors++; $display("FAIL flush_mask got=%b required=0011", mask); end
`endif
    for (int k = 0; k < 4; k++) begin b[k] = rnd(); send(b[k], 1'b0, 1'b1); end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_data[OW-1:0] !== b[0]) begin errors++; $display("FAIL flush_next_seg0 got=%h required=%h", out_data[OW-1:0], b[0]); end
  endtask
  task automatic test_backpressure();
    logic [OW-1:0] b[4];
    logic [IW+CW-1:0] snap;
    logic ok;
    cfg_nx = 1;
    for (int k = 0; k < 4; k++) send(rnd(), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0);
    snap = out_data;
    checks++; if (out_pvld !== 1'b1) begin errors++; $display("FAIL bp_held pvld=%b required=1", out_pvld); end
    for (int k = 0; k < 3; k++) begin
      b[k] = rnd(); tick(1'b1, {1'b0, b[k]}, 1'b0);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_nonfinal beat=%0d acc=%b required=1", k, acc); end
    end
    b[3] = rnd(); ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, {1'b0, b[3]}, 1'b0);
      if (acc || !out_pvld || out_data !== snap) ok = 0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold stable=%b required=1", ok); end
    tick(1'b1, {1'b0, b[3]}, 1'b1);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_handoff acc=%b required=1", acc); end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== {1'b0, b[3], b[2], b[1], b[0]})
      begin errors++; $display("FAIL bp_new pvld=%b seg3=%h required=%h", out_pvld, out_data[3*OW +: OW], b[3]); end
    tick(1'b0, '0, 1'b1);
    checks++; if (out_pvld !== 1'b0) begin errors++; $display("FAIL bp_drain pvld=%b required=0", out_pvld); end
  endtask
  task automatic test_back_to_back();
    int n0;
    logic ok;
    cfg_nx = 1; n0 = n_out; ok = 1;
    for (int k = 0; k < 64; k++) begin tick(1'b1, {1'b0, rnd()}, 1'b1); if (!acc) ok = 0; end
    tick(1'b0, '0, 1'b1); tick(1'b0, '0, 1'b1);
    checks++; if (!ok) begin errors++; $display("FAIL stream_bubble no_stall=%b required=1", ok); end
    checks++; if (n_out - n0 != 16) begin errors++; $display("FAIL stream_words got=%0d required=16", n_out - n0); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if (pend.size() == 0 && $urandom_range(5) == 0) cfg_nx = 1'($urandom_range(1));
      tick(1'($urandom_range(3) != 0), {1'($urandom_range(7) == 0), rnd()}, 1'($urandom_range(1)));
    end
    for (int k = 0; k < 8; k++) tick(1'b0, '0, 1'b1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain left=%0d required=0", exp_q.size()); end
  endtask
  task automatic test_reset_mid();
    logic [OW-1:0] b[4];
    cfg_nx = 1;
    for (int k = 0; k < 6; k++) send(rnd(), 1'b0, 1'b0);
    @(negedge clk); rstn = 0; inp_pvld = 0; #1;
    exp_q.delete(); pend.delete();
    checks++; if (out_pvld !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rst_mid pvld=%b seg0=%h required=0", out_pvld, out_data[OW-1:0]); end
    checks++; if (mask !== '0) begin errors++; $display("FAIL rst_mid_mask got=%b required=0", mask); end
    @(negedge clk); rstn = 1;
    for (int k = 0; k < 4; k++) begin b[k] = rnd(); send(b[k], 1'b0, 1'b1); end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== {1'b0, b[3], b[2], b[1], b[0]})
      begin errors++; $display("FAIL rst_clean pvld=%b seg0=%h required=%h", out_pvld, out_data[OW-1:0], b[0]); end
  endtask
  initial begin
    test_reset();
    test_full();
    test_half();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    tick(1'b0, '0, 1'b1); tick(1'b0, '0, 1'b1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL end_pending left=%0d required=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
